// File: rtl/gpio_host_master_if.sv
// Command handshake bundle between a command source and gpio_host_master.
// master: drives cmd_valid/cmd_ctrl/cmd_data/cmd_rst, observes cmd_ready.
// slave:  observes the command fields, drives cmd_ready.
interface gpio_host_master_if #(
    parameter int DATA_LEN = 24
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_ctrl;
    logic [DATA_LEN-1:0] cmd_data;
    logic                cmd_rst;

    modport master (
        output cmd_valid, cmd_ctrl, cmd_data, cmd_rst,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ctrl, cmd_data, cmd_rst,
        output cmd_ready
    );
endinterface

// File: rtl/gpio_host_master.sv
// Host-side initiator for the 32-bit GPIO command link into the conv accelerator.
// Sequences each command as setup (valid=0), strobe (valid=1), release (valid=0).
// Ports:
//   i_CLK, i_reset       clock, synchronous active-high reset
//   cmd (slave)          command handshake: valid/ready, ctrl, data, rst
//   o_gpio_o_data        word to accelerator {ctrl,valid,3'b0,data,rst}
//   i_gpio_i_data        word from accelerator
//   o_rsp_valid          1-cycle pulse after a Data_request completes
//   o_rsp_data           captured return word
//   o_busy               high whenever a command is in flight
module gpio_host_master #(
    parameter int GPIO_D      = 32,
    parameter int DATA_LEN    = 24,
    parameter int GAP_CYCLES  = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              i_CLK,
    input  logic              i_reset,
    gpio_host_master_if.slave cmd,
    output logic [GPIO_D-1:0] o_gpio_o_data,
    input  logic [GPIO_D-1:0] i_gpio_i_data,
    output logic              o_rsp_valid,
    output logic [GPIO_D-1:0] o_rsp_data,
    output logic              o_busy
);
    localparam int MAXC = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    CTRL_DREQ = 3'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [2:0]          r_ctrl;
    logic                r_valid;
    logic [DATA_LEN-1:0] r_data;
    logic                r_rst;
    logic                r_rsp_valid;
    logic [GPIO_D-1:0]   r_rsp_data;
    logic                w_accept;
    logic                w_last_rel;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_last_rel  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = cmd.cmd_valid;
                if (cmd.cmd_valid) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = GAP_LOAD;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = STROBE;
                    w_cnt_nxt   = HOLD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RELEASE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_last_rel  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ctrl      <= 3'd0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_rst       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // valid is registered so it rises/falls exactly on STROBE entry/exit
            r_valid <= (w_state_nxt == STROBE);
            if (w_accept) begin
                r_ctrl <= cmd.cmd_ctrl;
                r_data <= cmd.cmd_data;
                r_rst  <= cmd.cmd_rst;
            end
            r_rsp_valid <= w_last_rel && (r_ctrl == CTRL_DREQ);
            if (w_last_rel && (r_ctrl == CTRL_DREQ))
                r_rsp_data <= i_gpio_i_data;
        end
    end

    // ctrl/data/rst persist in IDLE; the accelerator's run mode relies on it
    assign o_gpio_o_data = {r_ctrl, r_valid, 3'b000, r_data, r_rst};
    assign cmd.cmd_ready = (r_state == IDLE) && !i_reset;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_busy        = (r_state != IDLE);
endmodule

// File: tb/tb_gpio_host_master.sv
// Directed self-checking bench for gpio_host_master (GAP=2, HOLD=4).
// Each task drives one scenario and compares against hand-computed words.
module tb_gpio_host_master;
    logic        clk;
    logic        rst;
    logic [31:0] gpio_o;
    logic [31:0] gpio_i;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    int checks;
    int errors;

    gpio_host_master_if #(.DATA_LEN(24)) cmd_if ();

    gpio_host_master #(
        .GPIO_D(32), .DATA_LEN(24), .GAP_CYCLES(2), .HOLD_CYCLES(4)
    ) dut (
        .i_CLK         (clk),
        .i_reset       (rst),
        .cmd           (cmd_if.slave),
        .o_gpio_o_data (gpio_o),
        .i_gpio_i_data (gpio_i),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command, wait (bounded) for ready, return one sample after accept.
    task automatic send(input logic [2:0] c, input logic [23:0] d, input logic r);
        int n;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ctrl  = c;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_rst   = r;
        n = 0;
        while (!cmd_if.cmd_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: ready=%0b required 1", cmd_if.cmd_ready);
        end
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %0b required 0", cmd_if.cmd_ready);
        end
        checks++;
        if (gpio_o !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_word: got %h required 00000001", gpio_o);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_busy: got v=%0b d=%h b=%0b required 0/0/0",
                     rsp_valid, rsp_data, busy);
        end
        rst = 1'b0;
        step();
        step();
        checks++;
        if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || gpio_o !== 32'h0000_0001) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%0b busy=%0b word=%h required 1/0/00000001",
                     cmd_if.cmd_ready, busy, gpio_o);
        end
    endtask

    task automatic test_word_sequence();
        logic [31:0] exp;
        int bad;
        send(3'd0, 24'h010203, 1'b0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            exp = (k >= 2 && k <= 5) ? 32'h1002_0406 : 32'h0002_0406;
            if (gpio_o !== exp || cmd_if.cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL word_seq[%0d]: got %h rdy=%0b busy=%0b required %h 0 1",
                         k, gpio_o, cmd_if.cmd_ready, busy, exp);
            end
            step();
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || gpio_o !== 32'h0002_0406) begin
            errors++;
            $display("FAIL ready_return: got rdy=%0b busy=%0b word=%h required 1 0 00020406",
                     cmd_if.cmd_ready, busy, gpio_o);
        end
    endtask

    task automatic test_response();
        int pulses;
        int pulse_at;
        logic [31:0] got;
        gpio_i = 32'h0000_1ABC;
        send(3'd3, 24'h000000, 1'b0);
        pulses = 0;
        pulse_at = -1;
        got = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (rsp_valid === 1'b1) begin
                pulses++;
                pulse_at = k;
                got = rsp_data;
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != 8) begin
            errors++;
            $display("FAIL dreq_pulse: got %0d pulses at %0d required 1 at 8", pulses, pulse_at);
        end
        checks++;
        if (got !== 32'h0000_1ABC) begin
            errors++;
            $display("FAIL dreq_data: got %h required 00001abc", got);
        end
        gpio_i = 32'hDEAD_BEEF;
        send(3'd1, 24'h000020, 1'b0);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || rsp_data !== 32'h0000_1ABC) begin
            errors++;
            $display("FAIL no_rsp_ctrl1: got %0d pulses data=%h required 0 00001abc",
                     pulses, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] trace;
        logic [17:0] exp_trace;
        logic [31:0] second_word;
        // samples 2-5 and 11-14 carry valid=1; sample 8 is the lone IDLE cycle
        exp_trace = 18'b000111100000111100;
        trace = '0;
        second_word = '0;
        send(3'd2, 24'h0000AA, 1'b0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = 24'h000055;
        for (int k = 0; k < 18; k++) begin
            trace[k] = gpio_o[28];
            if (k == 11) second_word = gpio_o;
            if (k == 9) cmd_if.cmd_valid = 1'b0;
            step();
        end
        checks++;
        if (trace !== exp_trace) begin
            errors++;
            $display("FAIL b2b_valid_trace: got %b required %b", trace, exp_trace);
        end
        checks++;
        if (second_word !== 32'h5000_00AA) begin
            errors++;
            $display("FAIL b2b_second_word: got %h required 500000aa", second_word);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int seen;
        gpio_i = 32'h0000_0777;
        send(3'd3, 24'h000001, 1'b0);
        step();
        step();
        checks++;
        if (gpio_o !== 32'h7000_0002) begin
            errors++;
            $display("FAIL mid_strobe_word: got %h required 70000002", gpio_o);
        end
        rst = 1'b1;
        step();
        checks++;
        if (gpio_o !== 32'h0000_0001 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_word: got %h busy=%0b rsp=%0b required 00000001 0 0",
                     gpio_o, busy, rsp_valid);
        end
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rsp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_no_pulse: got %0d pulses required 0", pulses);
        end
        gpio_i = 32'h0055_AA33;
        send(3'd3, 24'h000000, 1'b1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rsp_valid === 1'b1 && rsp_data === 32'h0055_AA33) seen++;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL post_reset_dreq: got %0d good pulses required 1", seen);
        end
    endtask

    task automatic test_run_mode();
        int bad;
        send(3'd4, 24'h000000, 1'b0);
        for (int k = 0; k < 8; k++) step();
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (gpio_o[31:29] !== 3'b100 || gpio_o[28] !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run_mode_hold: got %0d bad cycles required 0", bad);
        end
        checks++;
        if (gpio_o !== 32'h8000_0000) begin
            errors++;
            $display("FAIL run_mode_word: got %h required 80000000", gpio_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        gpio_i = 32'h0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ctrl  = 3'd0;
        cmd_if.cmd_data  = 24'h0;
        cmd_if.cmd_rst   = 1'b0;
        test_reset();
        test_word_sequence();
        test_response();
        test_back_to_back();
        test_reset_mid();
        test_run_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
